// File: rtl/decode_queue.sv
// Instruction decode stage feeding a DEPTH-entry elastic queue of decoded bundles.
// Decode is combinational on the incoming word; only the decoded result is stored.
module decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_regwrite,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic             out_branch,
  output logic             out_jump,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CQ_W  = PTR_W + 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
    OP_OR   = 4'd4,  OP_SLT = 4'd5, OP_ADDI = 4'd6, OP_LW = 4'd7,
    OP_SW   = 4'd8,  OP_J   = 4'd9, OP_BEQ = 4'd10, OP_ILL = 4'd15
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            jump;
  } entry_t;

  function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    entry_t e;
    e     = '0;
    e.op  = OP_ILL;
    e.rs  = instr[25:21];
    e.rt  = instr[20:16];
    e.rd  = instr[15:11];
    e.pc  = pc;
    case (instr[31:26])
      6'b000000: begin
        case (instr[5:0])
          6'b100000: e.op = OP_ADD;
          6'b100010: e.op = OP_SUB;
          6'b100100: e.op = OP_AND;
          6'b100101: e.op = OP_OR;
          6'b101010: e.op = OP_SLT;
          6'b000000: e.op = OP_NOP;
          default:   e.op = OP_ILL;
        endcase
      end
      6'b001000: e.op = OP_ADDI;
      6'b100011: e.op = OP_LW;
      6'b101011: e.op = OP_SW;
      6'b000010: e.op = OP_J;
      6'b000100: e.op = OP_BEQ;
      default:   e.op = OP_ILL;
    endcase
    case (e.op)
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: e.imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
      OP_J:                          e.imm = {{(XLEN-28){1'b0}}, instr[25:0], 2'b00};
      default:                       e.imm = '0;
    endcase
    e.regwrite = (e.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LW});
    e.memread  = (e.op == OP_LW);
    e.memwrite = (e.op == OP_SW);
    e.branch   = (e.op == OP_BEQ);
    e.jump     = (e.op == OP_J);
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  entry_t            r_mem [DEPTH];
  logic [CQ_W-1:0]   r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_ill_cnt;

  entry_t            w_dec;
  entry_t            w_head;
  logic              w_push;
  logic              w_pop;

  assign w_dec     = decode(in_instr, in_pc);
  // Ready depends on registered occupancy only, so a pop never frees a slot in the same cycle.
  assign in_ready  = (r_count < CQ_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;
  assign w_head    = out_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_ill_cnt <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CQ_W'(1);
        2'b01:   r_count <= r_count - CQ_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && (w_dec.op == OP_ILL)) r_ill_cnt <= sat_inc(r_ill_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign out_op        = w_head.op;
  assign out_rs        = w_head.rs;
  assign out_rt        = w_head.rt;
  assign out_rd        = w_head.rd;
  assign out_imm       = w_head.imm;
  assign out_pc        = w_head.pc;
  assign out_regwrite  = w_head.regwrite;
  assign out_memread   = w_head.memread;
  assign out_memwrite  = w_head.memwrite;
  assign out_branch    = w_head.branch;
  assign out_jump      = w_head.jump;
  assign illegal_count = r_ill_cnt;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed instruction words with hand-decoded expectations.
module tb_decode_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int EW    = 4 + 15 + 2 * XLEN + 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_op;
  logic [4:0]       out_rs, out_rt, out_rd;
  logic [XLEN-1:0]  out_imm, out_pc;
  logic             out_regwrite, out_memread, out_memwrite, out_branch, out_jump;
  logic [CNT_W-1:0] illegal_count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_branch(out_branch), .out_jump(out_jump),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [3:0]      op;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] imm;
    logic [4:0]      flags;  // {regwrite, memread, memwrite, branch, jump}
  } vec_t;

  function automatic vec_t get_vec(input int i);
    vec_t v;
    case (i)
      0:  v = '{32'h2109FFFC, 4'd6,  5'd8,  5'd9,  5'd31, 64'hFFFF_FFFF_FFFF_FFFC, 5'b10000};
      1:  v = '{32'h08000010, 4'd9,  5'd0,  5'd0,  5'd0,  64'h40,                  5'b00001};
      2:  v = '{32'hFC000000, 4'd15, 5'd0,  5'd0,  5'd0,  64'h0,                   5'b00000};
      3:  v = '{32'h012A4020, 4'd1,  5'd9,  5'd10, 5'd8,  64'h0,                   5'b10000};
      4:  v = '{32'h012A4022, 4'd2,  5'd9,  5'd10, 5'd8,  64'h0,                   5'b10000};
      5:  v = '{32'h012A4024, 4'd3,  5'd9,  5'd10, 5'd8,  64'h0,                   5'b10000};
      6:  v = '{32'h012A4025, 4'd4,  5'd9,  5'd10, 5'd8,  64'h0,                   5'b10000};
      7:  v = '{32'h012A402A, 4'd5,  5'd9,  5'd10, 5'd8,  64'h0,                   5'b10000};
      8:  v = '{32'h8D280004, 4'd7,  5'd9,  5'd8,  5'd0,  64'h4,                   5'b11000};
      9:  v = '{32'hAD28FFF8, 4'd8,  5'd9,  5'd8,  5'd31, 64'hFFFF_FFFF_FFFF_FFF8, 5'b00100};
      10: v = '{32'h1109FFFF, 4'd10, 5'd8,  5'd9,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00010};
      11: v = '{32'h00000000, 4'd0,  5'd0,  5'd0,  5'd0,  64'h0,                   5'b00000};
      12: v = '{32'h012A4021, 4'd15, 5'd9,  5'd10, 5'd8,  64'h0,                   5'b00000};
      13: v = '{32'h3C010001, 4'd15, 5'd0,  5'd1,  5'd0,  64'h0,                   5'b00000};
      default: v = '{32'h0BFFFFFF, 4'd9, 5'd31, 5'd31, 5'd31, 64'h0000_0000_0FFF_FFFC, 5'b00001};
    endcase
    return v;
  endfunction

  logic [EW-1:0]    sb[$];
  int               checks = 0;
  int               fails  = 0;
  logic [CNT_W-1:0] exp_ill = '0;
  logic [XLEN-1:0]  pc_next = 64'hFFFF_0000_0000_1000;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] dut_bundle();
    return {out_op, out_rs, out_rt, out_rd, out_imm, out_pc,
            out_regwrite, out_memread, out_memwrite, out_branch, out_jump};
  endfunction

  // Caller is at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input int idx);
    vec_t v;
    bit   done;
    v = get_vec(idx);
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = pc_next;
    done     = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready) begin
        sb.push_back({v.op, v.rs, v.rt, v.rd, v.imm, pc_next, v.flags});
        if (v.op == 4'd15 && exp_ill != '1) exp_ill = exp_ill + 1'b1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    pc_next  = pc_next + 64'd4;
    if (!done) begin
      checks++; fails++;
      $display("FAIL push_timeout actual=in_ready_low required=accept idx=%0d", idx);
    end else begin
      chk("illegal_count", EW'(illegal_count), EW'(exp_ill));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_left", EW'(sb.size()), '0);
  endtask

  // Monitor: compare the head entry whenever the DUT hands one over.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (reset && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_entry actual=%0h required=none", dut_bundle());
        end else begin
          e = sb.pop_front();
          chk("entry", dut_bundle(), e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", EW'(out_valid), '0);
    chk("rst_in_ready",  EW'(in_ready),  EW'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", EW'(out_valid), '0);
    chk("rel_in_ready",  EW'(in_ready),  EW'(1));
    chk("rel_ill_cnt",   EW'(illegal_count), '0);
    chk("rel_payload",   dut_bundle(), '0);

    out_ready = 1'b1;
    push(0);
    chk("latency_valid", EW'(out_valid), EW'(1));
    chk("latency_op",    EW'(out_op),    EW'(6));
    push(1);
    push(2);
    chk("ill_cnt_first", EW'(illegal_count), EW'(1));
    drain();

    // Fill the queue with the consumer stalled; third word must wait.
    out_ready = 1'b0;
    push(3);
    push(4);
    chk("full_in_ready",  EW'(in_ready),  '0);
    chk("full_out_valid", EW'(out_valid), EW'(1));
    in_valid = 1'b1;
    in_instr = get_vec(5).instr;
    in_pc    = pc_next;
    repeat (2) begin
      @(negedge clk);
      chk("held_in_ready", EW'(in_ready), '0);
    end
    out_ready = 1'b1;
    push(5);
    drain();

    // Flush a full queue while a word is offered.
    out_ready = 1'b0;
    push(6);
    push(7);
    chk("pre_flush_ready", EW'(in_ready), '0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = get_vec(8).instr;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", EW'(out_valid), '0);
    chk("flush_in_ready",  EW'(in_ready),  EW'(1));
    chk("flush_ill_cnt",   EW'(illegal_count), EW'(1));
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_dropped", EW'(out_valid), '0);

    for (int i = 8; i <= 14; i++) push(i);
    push(2);
    drain();
    chk("ill_cnt_sat", EW'(illegal_count), EW'(3));

    // Asynchronous reset with two entries queued.
    out_ready = 1'b0;
    push(0);
    push(3);
    chk("pre_rst_valid", EW'(out_valid), EW'(1));
    #2 reset = 1'b0;
    #1;
    chk("async_out_valid", EW'(out_valid), '0);
    chk("async_in_ready",  EW'(in_ready),  EW'(1));
    chk("async_ill_cnt",   EW'(illegal_count), '0);
    chk("async_payload",   dut_bundle(), '0);
    sb.delete();
    exp_ill = '0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    push(10);
    push(12);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
